// File: rtl/neander_pkg.sv
// Shared types for the Neander control unit: opcodes, ULA selects, FSM states
// and the control bundle that the state decode produces.
package neander_pkg;

    localparam int ADDR_W = 8;
    localparam int OP_W   = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_STA = 4'h1,
        OP_LDA = 4'h2,
        OP_ADD = 4'h3,
        OP_OR  = 4'h4,
        OP_AND = 4'h5,
        OP_NOT = 4'h6,
        OP_JMP = 4'h8,
        OP_JN  = 4'h9,
        OP_JZ  = 4'hA,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ULA_ADD    = 3'b000,
        ULA_AND    = 3'b001,
        ULA_OR     = 3'b010,
        ULA_NOT    = 3'b011,
        ULA_PASS_Y = 3'b100
    } ula_op_t;

    typedef enum logic [4:0] {
        S_RESET,
        S_F0, S_F1, S_F2, S_F3, S_DEC,
        S_A0, S_A1, S_A2,
        S_O0, S_O1, S_O2,
        S_EX_LDA, S_EX_ADD, S_EX_OR, S_EX_AND, S_EX_NOT,
        S_S0, S_S1,
        S_JP, S_SKIP,
        S_HALT
    } state_t;

    typedef struct packed {
        logic    pc_load;
        logic    pc_inc;
        logic    rem_load;
        logic    sel_rem;
        logic    rdm_load;
        logic    sel_rdm;
        logic    mem_write;
        logic    ri_load;
        logic    ac_load;
        logic    nz_load;
        ula_op_t sel_ula;
        logic    halted;
    } ctrl_t;

    // Moore output table: every control line is a function of the state alone.
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_F0, S_A0: c.rem_load = 1'b1;
            S_F1, S_A1, S_SKIP: c.pc_inc = 1'b1;
            S_F2, S_A2, S_O2: c.rdm_load = 1'b1;
            S_F3: c.ri_load = 1'b1;
            S_O0: begin
                c.rem_load = 1'b1;
                c.sel_rem  = 1'b1;
            end
            S_EX_LDA, S_EX_ADD, S_EX_OR, S_EX_AND, S_EX_NOT: begin
                c.ac_load = 1'b1;
                c.nz_load = 1'b1;
                case (s)
                    S_EX_LDA: c.sel_ula = ULA_PASS_Y;
                    S_EX_OR:  c.sel_ula = ULA_OR;
                    S_EX_AND: c.sel_ula = ULA_AND;
                    S_EX_NOT: c.sel_ula = ULA_NOT;
                    default:  c.sel_ula = ULA_ADD;
                endcase
            end
            S_S0: begin
                c.rem_load = 1'b1;
                c.sel_rem  = 1'b1;
                c.rdm_load = 1'b1;
                c.sel_rdm  = 1'b1;
            end
            S_S1:    c.mem_write = 1'b1;
            S_JP:    c.pc_load   = 1'b1;
            S_HALT:  c.halted    = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/neander_control_if.sv
// Control/datapath bundle: RI opcode and N/Z flags towards the control unit,
// load/increment/select strobes towards the datapath.
interface neander_control_if;

    logic [neander_pkg::OP_W-1:0] opcode;
    logic       flag_n;
    logic       flag_z;
    logic       pc_load;
    logic       pc_inc;
    logic       rem_load;
    logic       sel_rem;
    logic       rdm_load;
    logic       sel_rdm;
    logic       mem_write;
    logic       ri_load;
    logic       ac_load;
    logic       nz_load;
    logic [2:0] sel_ula;
    logic       halted;

    modport master (
        input  opcode, flag_n, flag_z,
        output pc_load, pc_inc, rem_load, sel_rem, rdm_load, sel_rdm,
               mem_write, ri_load, ac_load, nz_load, sel_ula, halted
    );

    modport slave (
        output opcode, flag_n, flag_z,
        input  pc_load, pc_inc, rem_load, sel_rem, rdm_load, sel_rdm,
               mem_write, ri_load, ac_load, nz_load, sel_ula, halted
    );

endinterface

// File: rtl/neander_control.sv
// Neander control unit: sequences fetch, decode, operand access and execute
// for one instruction at a time; parks in S_HALT on HLT until reset.
module neander_control
    import neander_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    neander_control_if.master bus
);

    state_t state, state_nx;
    ctrl_t  ctrl, ctrl_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: state_nx = S_F0;
            S_F0:    state_nx = S_F1;
            S_F1:    state_nx = S_F2;
            S_F2:    state_nx = S_F3;
            S_F3:    state_nx = S_DEC;
            S_DEC: begin
                case (bus.opcode)
                    OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: state_nx = S_A0;
                    OP_NOT:  state_nx = S_EX_NOT;
                    OP_JN:   state_nx = bus.flag_n ? S_A0 : S_SKIP;
                    OP_JZ:   state_nx = bus.flag_z ? S_A0 : S_SKIP;
                    OP_HLT:  state_nx = S_HALT;
                    default: state_nx = S_F0;
                endcase
            end
            S_A0: state_nx = S_A1;
            S_A1: state_nx = S_A2;
            S_A2: begin
                // RI stays put for the whole instruction, so later forks re-read it.
                case (bus.opcode)
                    OP_STA:                 state_nx = S_S0;
                    OP_JMP, OP_JN, OP_JZ:   state_nx = S_JP;
                    default:                state_nx = S_O0;
                endcase
            end
            S_O0: state_nx = S_O1;
            S_O1: state_nx = S_O2;
            S_O2: begin
                case (bus.opcode)
                    OP_ADD:  state_nx = S_EX_ADD;
                    OP_OR:   state_nx = S_EX_OR;
                    OP_AND:  state_nx = S_EX_AND;
                    default: state_nx = S_EX_LDA;
                endcase
            end
            S_S0:   state_nx = S_S1;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_F0;
        endcase
        ctrl_nx = ctrl_of(state_nx);
    end

    // Outputs are registered from the next state, so ctrl always equals ctrl_of(state).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RESET;
            ctrl  <= '0;
        end else begin
            state <= state_nx;
            ctrl  <= ctrl_nx;
        end
    end

    assign bus.pc_load   = ctrl.pc_load;
    assign bus.pc_inc    = ctrl.pc_inc;
    assign bus.rem_load  = ctrl.rem_load;
    assign bus.sel_rem   = ctrl.sel_rem;
    assign bus.rdm_load  = ctrl.rdm_load;
    assign bus.sel_rdm   = ctrl.sel_rdm;
    assign bus.mem_write = ctrl.mem_write;
    assign bus.ri_load   = ctrl.ri_load;
    assign bus.ac_load   = ctrl.ac_load;
    assign bus.nz_load   = ctrl.nz_load;
    assign bus.sel_ula   = ctrl.sel_ula;
    assign bus.halted    = ctrl.halted;

endmodule

// File: tb/tb_neander_control.sv
// Bench for neander_control: a behavioural Neander datapath runs small programs,
// and per-instruction timing expectations are queued and checked as they retire.
module tb_neander_control;
    import neander_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    neander_control_if bus();
    neander_control dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [256];
    logic [7:0] pc, rem, rdm, ri, ac, mem_out;
    logic       n, z;
    logic [7:0] pc_init = 8'h00;
    logic [7:0] ac_init = 8'h00;

    assign bus.opcode = ri[7:4];
    assign bus.flag_n = n;
    assign bus.flag_z = z;

    function automatic logic [7:0] ula(logic [2:0] op, logic [7:0] x, logic [7:0] y);
        case (op)
            3'b000:  return x + y;
            3'b001:  return x & y;
            3'b010:  return x | y;
            3'b011:  return ~x;
            3'b100:  return y;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] ula_now;
    assign ula_now = ula(bus.sel_ula, ac, rdm);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= pc_init; rem <= 8'h00; rdm <= 8'h00; ri <= 8'h00;
            ac <= ac_init; n <= 1'b0; z <= 1'b0; mem_out <= 8'h00;
        end else begin
            mem_out <= mem[rem];
            if (bus.mem_write) mem[rem] <= rdm;
            if (bus.pc_load) pc <= rdm;
            else if (bus.pc_inc) pc <= pc + 8'h01;
            if (bus.rem_load) rem <= bus.sel_rem ? rdm : pc;
            if (bus.rdm_load) rdm <= bus.sel_rdm ? ac : mem_out;
            if (bus.ri_load) ri <= rdm;
            if (bus.ac_load) ac <= ula_now;
            if (bus.nz_load) begin
                n <= ula_now[7];
                z <= (ula_now == 8'h00);
            end
        end
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         len;
        int         ac_off;
        int         wr_off;
        int         pcl_off;
        logic [2:0] ula;
    } exp_t;
    exp_t sb[$];

    // Cycle counts (from F0) and event positions straight from the opcode table.
    function automatic exp_t expect_of(logic [3:0] op, bit taken);
        exp_t e;
        e.len = 5; e.ac_off = 0; e.wr_off = 0; e.pcl_off = 0; e.ula = 3'b000;
        case (op)
            4'h1: begin e.len = 10; e.wr_off = 10; end
            4'h2: begin e.len = 12; e.ac_off = 12; e.ula = 3'b100; end
            4'h3: begin e.len = 12; e.ac_off = 12; e.ula = 3'b000; end
            4'h4: begin e.len = 12; e.ac_off = 12; e.ula = 3'b010; end
            4'h5: begin e.len = 12; e.ac_off = 12; e.ula = 3'b001; end
            4'h6: begin e.len = 6;  e.ac_off = 6;  e.ula = 3'b011; end
            4'h8: begin e.len = 9;  e.pcl_off = 9; end
            4'h9, 4'hA: begin
                if (taken) begin e.len = 9; e.pcl_off = 9; end
                else e.len = 6;
            end
            default: e.len = 5;
        endcase
        return e;
    endfunction

    task automatic push(logic [3:0] op, bit taken);
        sb.push_back(expect_of(op, taken));
    endtask

    function automatic ctrl_t outs();
        ctrl_t c;
        c.pc_load = bus.pc_load;   c.pc_inc = bus.pc_inc;
        c.rem_load = bus.rem_load; c.sel_rem = bus.sel_rem;
        c.rdm_load = bus.rdm_load; c.sel_rdm = bus.sel_rdm;
        c.mem_write = bus.mem_write; c.ri_load = bus.ri_load;
        c.ac_load = bus.ac_load;   c.nz_load = bus.nz_load;
        c.sel_ula = ula_op_t'(bus.sel_ula);
        c.halted = bus.halted;
        return c;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic start(logic [7:0] pc0, logic [7:0] ac0);
        rst = 1'b0;
        pc_init = pc0;
        ac_init = ac0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk8(string name, logic [7:0] got, logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %02h want %02h", name, got, want);
        end
    endtask

    // Retires instructions on each ri_load and checks them against the queue head.
    task automatic run_program(string name, int budget);
        int cyc = 0;
        int ri_cyc = -1;
        int off;
        int ac_off = 0, wr_off = 0, pcl_off = 0;
        logic [2:0] ula_seen = 3'b000;
        bit done = 0;
        exp_t e;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ri_cyc >= 0) begin
                off = cyc - ri_cyc + 4;
                if (bus.ac_load && ac_off == 0) begin ac_off = off; ula_seen = bus.sel_ula; end
                if (bus.mem_write && wr_off == 0) wr_off = off;
                if (bus.pc_load && pcl_off == 0) pcl_off = off;
            end
            if (bus.ri_load) begin
                if (ri_cyc >= 0) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL %s extra_instr: got len %0d want none", name, cyc - ri_cyc);
                    end else begin
                        e = sb.pop_front();
                        if ((cyc - ri_cyc) !== e.len) begin
                            fails++;
                            $display("FAIL %s len: got %0d want %0d", name, cyc - ri_cyc, e.len);
                        end
                        tests++;
                        if (ac_off !== e.ac_off) begin
                            fails++;
                            $display("FAIL %s ac_load_cycle: got %0d want %0d", name, ac_off, e.ac_off);
                        end
                        tests++;
                        if (wr_off !== e.wr_off) begin
                            fails++;
                            $display("FAIL %s mem_write_cycle: got %0d want %0d", name, wr_off, e.wr_off);
                        end
                        tests++;
                        if (pcl_off !== e.pcl_off) begin
                            fails++;
                            $display("FAIL %s pc_load_cycle: got %0d want %0d", name, pcl_off, e.pcl_off);
                        end
                        if (e.ac_off != 0) begin
                            tests++;
                            if (ula_seen !== e.ula) begin
                                fails++;
                                $display("FAIL %s sel_ula: got %03b want %03b", name, ula_seen, e.ula);
                            end
                        end
                    end
                end
                ri_cyc = cyc;
                ac_off = 0; wr_off = 0; pcl_off = 0; ula_seen = 3'b000;
            end
            if (bus.halted) done = 1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s halt_timeout: got no halt want halted within %0d cycles", name, budget);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s retired: got %0d pending want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        ctrl_t want;
        clear_mem();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_hold: got %h want 0", outs());
        end
        rst = 1'b1;
        #1;
        tests++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h want 0", outs());
        end
        want = '0;
        want.rem_load = 1'b1;
        @(negedge clk);
        tests++;
        if (outs() !== want) begin
            fails++;
            $display("FAIL reset_f0: got %h want %h", outs(), want);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (bus.rdm_load !== 1'b1) begin
            fails++;
            $display("FAIL f2_rdm_load: got %b want 1", bus.rdm_load);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_mid_f2: got %h want 0", outs());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (outs() !== want) begin
            fails++;
            $display("FAIL restart_f0: got %h want %h", outs(), want);
        end
    endtask

    task automatic test_reset_store();
        bit seen = 0;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h81; mem[2] = 8'hF0;
        start(8'h00, 8'h5A);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_write) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL sta_write_seen: got none want mem_write within 40 cycles");
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.mem_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_s1_write: got %b want 0", bus.mem_write);
        end
        @(posedge clk);
        #1;
        chk8("reset_s1_mem", mem[8'h81], 8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_lda();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'hF0; mem[8'h80] = 8'h05;
        push(4'h2, 0);
        start(8'h00, 8'h00);
        run_program("lda", 200);
        chk8("lda_ac", ac, 8'h05);
        chk8("lda_nz", {6'b0, n, z}, 8'h00);
        chk8("lda_pc", pc, 8'h03);
    endtask

    task automatic test_add_sta();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h82;
        mem[2] = 8'h30; mem[3] = 8'h83;
        mem[4] = 8'h10; mem[5] = 8'h81;
        mem[6] = 8'hF0;
        mem[8'h82] = 8'h03; mem[8'h83] = 8'h04;
        push(4'h2, 0); push(4'h3, 0); push(4'h1, 0);
        start(8'h00, 8'h00);
        run_program("add_sta", 200);
        chk8("sta_mem", mem[8'h81], 8'h07);
        chk8("add_ac", ac, 8'h07);
        chk8("add_sta_pc", pc, 8'h07);
    endtask

    task automatic test_jn();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'h90; mem[3] = 8'h40;
        mem[8'h40] = 8'hF0; mem[8'h80] = 8'h85;
        push(4'h2, 0); push(4'h9, 1);
        start(8'h00, 8'h00);
        run_program("jn_taken", 200);
        chk8("jn_taken_pc", pc, 8'h41);
        mem[8'h80] = 8'h05; mem[4] = 8'hF0;
        push(4'h2, 0); push(4'h9, 0);
        start(8'h00, 8'h00);
        run_program("jn_skip", 200);
        chk8("jn_skip_pc", pc, 8'h05);
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h80;
        mem[2] = 8'h40; mem[3] = 8'h81;
        mem[4] = 8'h50; mem[5] = 8'h82;
        mem[6] = 8'hA0; mem[7] = 8'h40;
        mem[8] = 8'h80; mem[9] = 8'h30;
        mem[8'h30] = 8'h20; mem[8'h31] = 8'h83;
        mem[8'h32] = 8'hA0; mem[8'h33] = 8'h50;
        mem[8'h50] = 8'hF0;
        mem[8'h80] = 8'h0C; mem[8'h81] = 8'h03; mem[8'h82] = 8'h05; mem[8'h83] = 8'h00;
        push(4'h2, 0); push(4'h4, 0); push(4'h5, 0); push(4'hA, 0);
        push(4'h8, 1); push(4'h2, 0); push(4'hA, 1);
        start(8'h00, 8'h00);
        run_program("back_to_back", 400);
        chk8("b2b_ac", ac, 8'h00);
        chk8("b2b_z", {7'b0, z}, 8'h01);
        chk8("b2b_pc", pc, 8'h51);
    endtask

    task automatic test_nop_illegal();
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'hB0; mem[2] = 8'h70; mem[3] = 8'hC0; mem[4] = 8'hF0;
        push(4'h0, 0); push(4'hB, 0); push(4'h7, 0); push(4'hC, 0);
        start(8'h00, 8'h33);
        run_program("nop_illegal", 200);
        chk8("nop_ac", ac, 8'h33);
        chk8("nop_pc", pc, 8'h05);
    endtask

    task automatic test_halt();
        ctrl_t want;
        logic [7:0] pc_h;
        int bad = 0;
        clear_mem();
        mem[0] = 8'hF0;
        start(8'h00, 8'h00);
        run_program("halt", 50);
        pc_h = pc;
        chk8("halt_pc", pc_h, 8'h01);
        want = '0;
        want.halted = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (outs() !== want || pc !== pc_h) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[8'hFF] = 8'h60; mem[0] = 8'hF0;
        push(4'h6, 0);
        start(8'hFF, 8'h0F);
        run_program("pc_wrap", 200);
        chk8("wrap_ac", ac, 8'hF0);
        chk8("wrap_n", {7'b0, n}, 8'h01);
        chk8("wrap_pc", pc, 8'h01);
    endtask

    initial begin
        test_reset();
        test_reset_store();
        test_lda();
        test_add_sta();
        test_jn();
        test_back_to_back();
        test_nop_illegal();
        test_halt();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
